// File: rtl/neuro_serial_host.sv
// Serial host for a bit-serial inference core: streams a weight word once, then
// exchanges input frames and result frames with the core over a single-wire pair.
module neuro_serial_host #(
  parameter int W_BITS   = 250,
  parameter int IN_BITS  = 14,
  parameter int OUT_BITS = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_load,
  input  logic [W_BITS-1:0]   w_data,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                in_ready,
  output logic                D_OUT_SERIAL,
  input  logic                D_IN_SERIAL,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  output logic                w_loaded,
  output logic                busy
);

  // state  | meaning
  // IDLE   | line low, waiting for w_load or an accepted frame
  // LOAD_W | shifting the weight word out, MSB first
  // TX     | shifting the input frame out, MSB first
  // GAP    | one turnaround cycle, line low
  // RX     | sampling the result from the core, MSB first
  localparam int CW = $clog2(W_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_TX, S_GAP, S_RX} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [W_BITS-1:0]   r_wsh;
  logic [IN_BITS-1:0]  r_ish;
  logic [OUT_BITS-1:0] r_osh;
  logic [OUT_BITS-1:0] r_out_data;
  logic                r_out_valid;
  logic                r_w_loaded;
  logic                w_last;
  logic                w_accept;
  logic [OUT_BITS-1:0] w_rx_word;

  assign w_last    = (r_cnt == '0);
  assign w_rx_word = {r_osh[OUT_BITS-2:0], D_IN_SERIAL};

  // A frame may be taken at the tail of a weight load or result read so TX follows with no bubble.
  assign in_ready = r_w_loaded &
                    (((r_state == S_IDLE) & ~w_load) |
                     ((r_state == S_LOAD_W) & w_last) |
                     ((r_state == S_RX) & w_last));
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt = S_LOAD_W;
          w_cnt_nxt   = CW'(W_BITS - 1);
        end else if (w_accept) begin
          w_state_nxt = S_TX;
          w_cnt_nxt   = CW'(IN_BITS - 1);
        end
      end
      S_LOAD_W: begin
        if (!w_last) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (w_accept) begin
          w_state_nxt = S_TX;
          w_cnt_nxt   = CW'(IN_BITS - 1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TX: begin
        if (w_last) w_state_nxt = S_GAP;
        else        w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_GAP: begin
        w_state_nxt = S_RX;
        w_cnt_nxt   = CW'(OUT_BITS - 1);
      end
      S_RX: begin
        if (!w_last) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (w_accept) begin
          w_state_nxt = S_TX;
          w_cnt_nxt   = CW'(IN_BITS - 1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wsh       <= '0;
      r_ish       <= '0;
      r_osh       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_w_loaded  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_load)        r_wsh <= w_data;
          else if (w_accept) r_ish <= in_data;
        end
        S_LOAD_W: begin
          r_wsh <= r_wsh << 1;
          if (w_last) begin
            r_w_loaded <= 1'b1;
            if (w_accept) r_ish <= in_data;
          end
        end
        S_TX: r_ish <= r_ish << 1;
        S_RX: begin
          r_osh <= w_rx_word;
          if (w_last) begin
            r_out_data  <= w_rx_word;
            r_out_valid <= 1'b1;
            if (w_accept) r_ish <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    D_OUT_SERIAL = 1'b0;
    case (r_state)
      S_LOAD_W: D_OUT_SERIAL = r_wsh[W_BITS-1];
      S_TX:     D_OUT_SERIAL = r_ish[IN_BITS-1];
      default:  D_OUT_SERIAL = 1'b0;
    endcase
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign w_loaded  = r_w_loaded;
  assign busy      = (r_state != S_IDLE);

endmodule
